bicubic_stream_framer: RTL and testbench
========================================

# bicubic_stream_framer

Synthesizable framing stage between the 24-bit source-pixel stream (BGR, raster order, valid/ready) and the bicubic upscaler input. On a start pulse it accepts exactly one frame of `WIDTH*HEIGHT` pixels. Each pixel is tagged with start-of-frame, end-of-line and end-of-frame sideband bits. Pixels pass through a 2-entry skid buffer so both sides see fully registered handshakes, and the block pulses `frame_done` once the last pixel has left.

## Interface
- `WIDTH`, default `SRC_IMG_WIDTH`: pixels per line; must be ≥2.
- `HEIGHT`, default `SRC_IMG_HEIGHT`: lines per frame; must be ≥1.
- `DW`, default 24: pixel width `{R,G,B}`.
- `clk`, input, 1: clock; all state on rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `start`, input, 1: single-cycle frame start; honoured only in IDLE.
- `s_valid`, input, 1: upstream pixel valid.
- `s_ready`, output, 1: block can accept a pixel.
- `s_data`, input, DW: upstream pixel.
- `m_valid`, output, 1: output pixel valid.
- `m_ready`, input, 1: downstream accepts.
- `m_data`, output, DW: output pixel.
- `m_sof`, output, 1: first pixel of frame (row 0, col 0).
- `m_eol`, output, 1: last pixel of a line (col `WIDTH-1`).
- `m_eof`, output, 1: last pixel of frame.
- `busy`, output, 1: state is not IDLE.
- `frame_done`, output, 1: one-cycle pulse when the frame has fully drained.
- `frame_cnt`, output, 16: completed frames; wraps `0xFFFF`→0.

## Operation
- States:
  - IDLE: `start`→RUN; counters cleared on entry.
  - RUN: accept pixels; on input handshake of the last pixel (col=`WIDTH-1`, row=`HEIGHT-1`), go to DRAIN.
  - DRAIN: wait until the buffer is empty, then go to IDLE. On the transition cycle, pulse `frame_done` and increment `frame_cnt`.
- Input handshake is `s_valid & s_ready`; output handshake is `m_valid & m_ready`.
- `s_ready` = (state==RUN) && (occupancy<2); driven from registered state.
- Counters:
  - `col` and `row` are `$clog2` width and advance on input handshake only.
  - `col` wraps at `WIDTH-1`→0 and increments `row`.
- Tags are computed at input from `col`/`row` and stored with the data. Each buffer entry is DW+3 bits.
- Skid buffer:
  - 2-entry FIFO; output is taken from the head register.
  - `m_valid` = occupancy≠0.
  - `m_*` hold stable while `m_valid & ~m_ready`.
- Occupancy rules:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged, with data order preserved.
  - At occupancy 2 push is impossible because `s_ready`=0.
- `start` outside IDLE is ignored.
- `s_valid` in IDLE or DRAIN is not accepted; upstream holds its data.
- Reset values:
  - `s_ready`=0, `m_valid`=0, `m_data`=0, `m_sof`/`m_eol`/`m_eof`=0.
  - `busy`=0, `frame_done`=0, `frame_cnt`=0.
  - State IDLE, occupancy 0, `col`=`row`=0.
- Reset asserted mid-frame discards buffered pixels and returns to IDLE; `frame_done` is not pulsed.

## Timing
- Start: `start` sampled at edge N; `s_ready` can be 1 from the cycle after edge N.
- Latency: pixel accepted at edge N appears on `m_data` with `m_valid`=1 after edge N, when the buffer was empty.
- Throughput: 1 pixel/cycle when `m_ready` is held high.
- Backpressure: with `m_ready`=0 for ≥2 cycles, `s_ready` drops after the 2nd accepted pixel. It returns the cycle after the next pop.
- Drain and done:
  - The `m_eof` pixel pops at edge M.
  - `frame_done`=1 during the cycle after edge M, and `busy` falls at the same time.
  - `frame_cnt` updates at edge M+1.
- Back-to-back frames: `start` asserted during the `frame_done` cycle is ignored, since the state is not yet IDLE. It is honoured one cycle later.

## Test plan
- WIDTH=4, HEIGHT=3, `start`, `s_valid`=1, `m_ready`=1, data 0..11 → outputs 0..11 in order:
  - `m_sof` on 0 only.
  - `m_eol` on 3, 7, 11.
  - `m_eof` on 11.
  - `frame_done` one cycle after 11 pops; `frame_cnt`=1.
- Same frame with `m_ready`=0 for 5 cycles mid-stream → exactly 2 pixels buffered, `s_ready`=0, no loss or duplication.
- Random `s_valid`/`m_ready` (50%) over 3 frames → output sequence and tags match the model; `frame_cnt`=3.
- `s_valid`=1 before `start` for 10 cycles → `s_ready`=0, nothing accepted; first output is the first pixel after `start`.
- `rst_n` pulsed low after pixel 5 → all outputs return to reset values immediately.
  - Next `start` yields `m_sof` on the first new pixel; `frame_cnt`=0.
- `start` held high through a frame → only one frame processed per IDLE entry; extra pixels rejected during DRAIN.

Source files
------------

// File: rtl/bicubic_stream_framer.sv
// Frames one WIDTH*HEIGHT pixel stream per start pulse, tags SOF/EOL/EOF at the input,
// and decouples the upstream and downstream handshakes through a 2-entry skid buffer.
`ifndef SRC_IMG_WIDTH
`define SRC_IMG_WIDTH 640
`endif
`ifndef SRC_IMG_HEIGHT
`define SRC_IMG_HEIGHT 480
`endif

module bicubic_stream_framer #(
    parameter int unsigned WIDTH  = `SRC_IMG_WIDTH,
    parameter int unsigned HEIGHT = `SRC_IMG_HEIGHT,
    parameter int unsigned DW     = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_sof,
    output logic          m_eol,
    output logic          m_eof,
    output logic          busy,
    output logic          frame_done,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned EW = DW + 3;
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0]    occ;
    logic [1:0]    occ_next;
    logic [EW-1:0] head;
    logic [EW-1:0] tail;
    logic [EW-1:0] head_next;
    logic [EW-1:0] tail_next;
    logic [EW-1:0] in_entry;
    logic          push;
    logic          pop;
    logic          last_px;
    logic          done_next;

    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;
    assign last_px = (col == COL_LAST) && (row == ROW_LAST);

    // Entry layout: {sof, eol, eof, data}
    assign in_entry = {(col == '0) && (row == '0), (col == COL_LAST), last_px, s_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        occ_next   = occ;
        head_next  = head;
        tail_next  = tail;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_RUN;
            ST_RUN:   if (push && last_px) state_next = ST_DRAIN;
            ST_DRAIN: if (occ == 2'd0) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        // Head register always feeds the output; tail only holds the second entry.
        case ({push, pop})
            2'b10: begin
                occ_next = occ + 2'd1;
                if (occ == 2'd0) begin
                    head_next = in_entry;
                end else begin
                    tail_next = in_entry;
                end
            end
            2'b01: begin
                occ_next  = occ - 2'd1;
                head_next = tail;
            end
            2'b11: begin
                head_next = in_entry;
            end
            default: ;
        endcase
    end

    // Frame has drained on the cycle the last buffered entry leaves during DRAIN.
    assign done_next = (state == ST_DRAIN) && (occ != 2'd0) && (occ_next == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ        <= 2'd0;
            head       <= '0;
            tail       <= '0;
            m_valid    <= 1'b0;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= 16'd0;
            col        <= '0;
            row        <= '0;
        end else begin
            occ        <= occ_next;
            head       <= head_next;
            tail       <= tail_next;
            m_valid    <= (occ_next != 2'd0);
            s_ready    <= (state_next == ST_RUN) && (occ_next != 2'd2);
            busy       <= (state_next != ST_IDLE) && !done_next;
            frame_done <= done_next;
            if ((state == ST_DRAIN) && (state_next == ST_IDLE)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (state == ST_IDLE) begin
                col <= '0;
                row <= '0;
            end else if (push) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    assign m_sof  = head[EW-1];
    assign m_eol  = head[EW-2];
    assign m_eof  = head[EW-3];
    assign m_data = head[DW-1:0];

endmodule

// File: tb/tb_bicubic_stream_framer.sv
// Randomized scoreboard bench for bicubic_stream_framer: frame-level reference model
// predicts accepted pixels, tags, handshake levels, frame_done, busy and frame_cnt.
module tb_bicubic_stream_framer;

    localparam int unsigned W    = 4;
    localparam int unsigned H    = 3;
    localparam int unsigned DW   = 24;
    localparam int unsigned NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic          busy;
    logic          frame_done;
    logic [15:0]   frame_cnt;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
        logic          eof;
    } px_t;

    px_t           q[$];
    px_t           e;
    int            n_cmp = 0;
    int            n_fail = 0;
    int            pix_k;
    bit            frame_open;
    bit            model_idle;
    bit            eof_pop_prev;
    bit            in_hs_last;
    bit            exp_done;
    logic [15:0]   exp_cnt;

    int            vpct;
    int            rpct;
    bit            offer;
    bit            rand_data;
    bit            stall;
    bit            start_req;
    bit            start_hold;
    logic [DW-1:0] data_ctr;

    bicubic_stream_framer #(.WIDTH(W), .HEIGHT(H), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_sof      (m_sof),
        .m_eol      (m_eol),
        .m_eof      (m_eof),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: advances on the negedge, predicting what the next posedge does.
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            q.delete();
            pix_k        = 0;
            frame_open   = 1'b0;
            model_idle   = 1'b1;
            eof_pop_prev = 1'b0;
            in_hs_last   = 1'b0;
            exp_cnt      = 16'd0;
        end else begin
            exp_done = eof_pop_prev;
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            chk("busy", 32'(busy), 32'(!model_idle && !exp_done));
            chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
            chk("m_valid", 32'(m_valid), 32'(q.size() != 0));
            chk("s_ready", 32'(s_ready), 32'(frame_open && (q.size() < 2)));

            in_hs_last = s_valid && s_ready;
            if (s_valid && s_ready && frame_open) begin
                e.d   = s_data;
                e.sof = (pix_k == 0);
                e.eol = ((pix_k % W) == (W - 1));
                e.eof = (pix_k == (NPIX - 1));
                q.push_back(e);
                pix_k++;
                if (pix_k == NPIX) frame_open = 1'b0;
            end

            eof_pop_prev = 1'b0;
            if (m_valid && m_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL output_unexpected: got pixel 0x%0h, expected none at %0t", m_data, $time);
                end else begin
                    e = q.pop_front();
                    chk("pixel", 32'({m_data, m_sof, m_eol, m_eof}), 32'(e));
                    eof_pop_prev = e.eof;
                end
            end

            if (model_idle && start) begin
                model_idle = 1'b0;
                frame_open = 1'b1;
                pix_k      = 0;
            end
            if (exp_done) begin
                exp_cnt    = exp_cnt + 16'd1;
                model_idle = 1'b1;
            end
        end
    end

    // One clock of stimulus; an offered pixel is held until it is accepted.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (!s_valid || in_hs_last) begin
            if (offer && (int'($urandom_range(99)) < vpct)) begin
                s_valid  = 1'b1;
                s_data   = rand_data ? DW'($urandom) : data_ctr;
                data_ctr = data_ctr + 1'b1;
            end else begin
                s_valid = 1'b0;
            end
        end
        m_ready   = stall ? 1'b0 : (int'($urandom_range(99)) < rpct);
        start     = start_req | start_hold;
        start_req = 1'b0;
    endtask

    task automatic run_frames(input int n, input int stall_at, input bit hold);
        logic [15:0] target;
        int          stall_cnt;
        bit          stall_used;
        int          budget;
        target     = exp_cnt + 16'(n);
        stall_cnt  = 0;
        stall_used = 1'b0;
        budget     = 600 * n;
        offer      = 1'b1;
        start_hold = hold;
        while ((exp_cnt != target) && (budget > 0)) begin
            start_req = !hold && model_idle;
            if ((stall_at >= 0) && !stall_used && (pix_k == stall_at) && frame_open) begin
                stall_used = 1'b1;
                stall_cnt  = 5;
            end
            stall = (stall_cnt > 0);
            cycle();
            if (stall_cnt == 1) begin
                chk("stall_s_ready", 32'(s_ready), 32'd0);
                chk("stall_m_valid", 32'(m_valid), 32'd1);
            end
            if (stall_cnt > 0) stall_cnt--;
            budget--;
        end
        if (exp_cnt != target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL frame_timeout: frames done %0d, required %0d", exp_cnt, target);
        end
        start_hold = 1'b0;
        start      = 1'b0;
        stall      = 1'b0;
        offer      = 1'b0;
        s_valid    = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data), 32'd0);
        chk({tag, "_tags"}, 32'({m_sof, m_eol, m_eof}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    endtask

    initial begin
        int budget;
        rst_n      = 1'b0;
        start      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        m_ready    = 1'b0;
        offer      = 1'b0;
        vpct       = 100;
        rpct       = 100;
        rand_data  = 1'b0;
        stall      = 1'b0;
        start_req  = 1'b0;
        start_hold = 1'b0;
        data_ctr   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Pixels offered before start must wait; the held pixel is the first one out.
        offer = 1'b1;
        repeat (10) cycle();
        chk("pre_start_s_ready", 32'(s_ready), 32'd0);
        run_frames(1, -1, 1'b0);
        chk("frame_cnt_after_first", 32'(frame_cnt), 32'd1);

        // Straight frame, data 0..11, full throughput.
        data_ctr = '0;
        run_frames(1, -1, 1'b0);
        chk("frame_cnt_after_directed", 32'(frame_cnt), 32'd2);

        // Downstream stall for 5 cycles mid-frame.
        data_ctr = '0;
        run_frames(1, 5, 1'b0);
        chk("frame_cnt_after_stall", 32'(frame_cnt), 32'd3);

        // Reset asserted right after pixel 5 has been accepted.
        data_ctr  = '0;
        offer     = 1'b1;
        start_req = 1'b1;
        budget    = 100;
        while (!(frame_open && (pix_k >= 6)) && (budget > 0)) begin
            cycle();
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL reset_setup_timeout: accepted %0d pixels, required 6", pix_k);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        s_valid = 1'b0;
        start   = 1'b0;
        offer   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        data_ctr = '0;
        run_frames(1, -1, 1'b0);
        chk("frame_cnt_after_reset", 32'(frame_cnt), 32'd1);

        // Random valid/ready at 50% over three frames.
        rand_data = 1'b1;
        vpct      = 50;
        rpct      = 50;
        run_frames(3, -1, 1'b0);
        chk("frame_cnt_after_random", 32'(frame_cnt), 32'd4);

        // Start held high through a whole frame; extra pixels are refused.
        vpct = 100;
        rpct = 100;
        run_frames(1, -1, 1'b1);
        offer = 1'b1;
        repeat (10) cycle();
        chk("held_start_busy", 32'(busy), 32'd0);
        chk("held_start_s_ready", 32'(s_ready), 32'd0);
        offer   = 1'b0;
        s_valid = 1'b0;
        repeat (2) cycle();
        chk("frame_cnt_after_held", 32'(frame_cnt), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
